// File: rtl/type_rule_cfg_writer.sv
// type_rule_cfg_writer: assembles multi-beat rule records from a 32-bit command stream and writes the type-lookup rule table
// Ports: i_clk/i_rst_n (async active-low reset); i_cfg_valid/i_cfg_data/o_cfg_ready command stream in;
//        o_rule_wren one-hot (or all-ones) strobe with o_typeRule_valid/typeData/typeMask/keyOffset record out;
//        o_resp_valid/o_resp_data/i_resp_ready one status word per command.
// Optional: define TYPE_RULE_CFG_CHECK_EN to reject writes whose typeData has bits outside typeMask (status 3).
module type_rule_cfg_writer #(
    parameter int TYPE_NUM         = 2,
    parameter int TYPE_WIDTH       = 16,
    parameter int KEY_FILED_NUM    = 8,
    parameter int KEY_OFFSET_WIDTH = 8,
    parameter int RULE_NUM         = 16
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst_n,
    input  logic                                     i_cfg_valid,
    input  logic [31:0]                              i_cfg_data,
    output logic                                     o_cfg_ready,
    output logic [RULE_NUM-1:0]                      o_rule_wren,
    output logic                                     o_typeRule_valid,
    output logic [TYPE_NUM*TYPE_WIDTH-1:0]           o_typeRule_typeData,
    output logic [TYPE_NUM*TYPE_WIDTH-1:0]           o_typeRule_typeMask,
    output logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0] o_typeRule_keyOffset,
    output logic                                     o_resp_valid,
    output logic [31:0]                              o_resp_data,
    input  logic                                     i_resp_ready
);
    localparam int TD = TYPE_NUM * TYPE_WIDTH;
    localparam int KO = KEY_FILED_NUM * KEY_OFFSET_WIDTH;
    localparam int DB = (TD + 31) / 32;
    localparam int OB = (KO + 31) / 32;
    localparam int NB = 2 * DB + OB;
    localparam int CW = $clog2(NB + 1);
    typedef enum logic [2:0] {IDLE, DATA, MASK, OFFS, DRAIN, COMMIT, RESP} state_t;
    state_t               r_state, w_next;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_op, w_op;
    logic [15:0]          r_idx, w_idx;
    logic [1:0]           r_status, w_status;
    logic [DB*32-1:0]     r_dbuf, r_mbuf;
    logic [OB*32-1:0]     r_obuf, w_obuf;
    logic [TD-1:0]        r_data, r_mask;
    logic [KO-1:0]        r_off;
    logic                 r_valid;
    logic [RULE_NUM-1:0]  r_wren, w_wren;
    logic                 w_fire, w_last, w_inr, w_bad;
    assign o_cfg_ready = (r_state != COMMIT) && (r_state != RESP);
    assign w_fire      = i_cfg_valid & o_cfg_ready;
    // In IDLE the header is still on the bus, so decode it directly rather than from the captured copy.
    assign w_op   = (r_state == IDLE) ? i_cfg_data[31:28] : r_op;
    assign w_idx  = (r_state == IDLE) ? i_cfg_data[15:0] : r_idx;
    assign w_inr  = {1'b0, w_idx} < 17'(RULE_NUM);
    assign w_wren = (w_op == 4'd3) ? '1 : RULE_NUM'(1) << w_idx;
    assign w_last = r_cnt == ((r_state == OFFS) ? CW'(OB - 1) : (r_state == DRAIN) ? CW'(NB - 1) : CW'(DB - 1));
`ifdef TYPE_RULE_CFG_CHECK_EN
    assign w_bad = |(r_dbuf[TD-1:0] & ~r_mbuf[TD-1:0]);
`else
    assign w_bad = 1'b0;
`endif
    // Offset record including the beat being accepted now, so COMMIT sees the final word.
    always_comb begin
        w_obuf = r_obuf;
        if (w_fire && r_state == OFFS) w_obuf[{r_cnt, 5'd0} +: 32] = i_cfg_data;
    end
    always_comb begin
        w_next   = r_state;
        w_status = r_status;
        case (r_state)
            IDLE: if (w_fire) begin
                w_status = (w_op == 4'd1 || w_op == 4'd2) ? (w_inr ? 2'd0 : 2'd2) : (w_op == 4'd3) ? 2'd0 : 2'd1;
                w_next   = (w_op == 4'd1) ? (w_inr ? DATA : DRAIN) : ((w_op == 4'd2 && w_inr) || w_op == 4'd3) ? COMMIT : RESP;
            end
            DATA:   if (w_fire && w_last) w_next = MASK;
            MASK:   if (w_fire && w_last) w_next = OFFS;
            OFFS: if (w_fire && w_last) begin
                w_next   = w_bad ? RESP : COMMIT;
                w_status = w_bad ? 2'd3 : 2'd0;
            end
            DRAIN:  if (w_fire && w_last) w_next = RESP;
            COMMIT: w_next = RESP;
            RESP:   if (i_resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_idx    <= '0;
            r_status <= '0;
            r_dbuf   <= '0;
            r_mbuf   <= '0;
            r_obuf   <= '0;
            r_data   <= '0;
            r_mask   <= '0;
            r_off    <= '0;
            r_valid  <= 1'b0;
            r_wren   <= '0;
        end else begin
            r_state  <= w_next;
            r_status <= w_status;
            r_cnt    <= (w_next != r_state) ? '0 : r_cnt + CW'(w_fire);
            r_obuf   <= w_obuf;
            r_wren   <= (w_next == COMMIT) ? w_wren : '0;
            if (r_state == IDLE && w_fire) begin
                r_op  <= w_op;
                r_idx <= w_idx;
            end
            if (w_fire && r_state == DATA) r_dbuf[{r_cnt, 5'd0} +: 32] <= i_cfg_data;
            if (w_fire && r_state == MASK) r_mbuf[{r_cnt, 5'd0} +: 32] <= i_cfg_data;
            if (w_next == COMMIT) r_valid <= w_op == 4'd1;
            if (r_state == OFFS && w_next == COMMIT) begin
                r_data <= r_dbuf[TD-1:0];
                r_mask <= r_mbuf[TD-1:0];
                r_off  <= w_obuf[KO-1:0];
            end
        end
    end
    assign o_rule_wren          = r_wren;
    assign o_typeRule_valid     = r_valid;
    assign o_typeRule_typeData  = r_data;
    assign o_typeRule_typeMask  = r_mask;
    assign o_typeRule_keyOffset = r_off;
    assign o_resp_valid         = r_state == RESP;
    assign o_resp_data          = {r_op, 10'b0, r_status, r_idx};
endmodule

// File: doc/type_rule_cfg_writer.md
Name: type_rule_cfg_writer

Overview:
Configuration-side writer for the parser's type-lookup rule table. It accepts a 32-bit command word stream from the control path (valid/ready) and assembles multi-beat rule records. It drives the table's per-rule one-hot write strobe together with rule valid, type data, type mask and key-offset fields. Every command returns a one-word status response, so software can confirm each table update.

Parameters:
TYPE_NUM, 2, number of type fields per rule
TYPE_WIDTH, 16, bits per type field
KEY_FILED_NUM, 8, number of key-offset fields per rule
KEY_OFFSET_WIDTH, 8, bits per key-offset field
RULE_NUM, 16, number of rule entries (max 65536)
Derived: DATA_BEATS = ceil(TYPE_NUM*TYPE_WIDTH/32); OFF_BEATS = ceil(KEY_FILED_NUM*KEY_OFFSET_WIDTH/32)

Ports:
i_clk  in  1  single clock
i_rst_n  in  1  reset, asynchronous, active-low
i_cfg_valid  in  1  command word valid
i_cfg_data  in  32  command word
o_cfg_ready  out  1  writer can accept a word this cycle
o_rule_wren  out  RULE_NUM  per-rule write strobe, one-cycle pulse
o_typeRule_valid  out  1  rule valid bit to write
o_typeRule_typeData  out  TYPE_NUM*TYPE_WIDTH  type[i] at bits [i*TYPE_WIDTH+:TYPE_WIDTH]
o_typeRule_typeMask  out  TYPE_NUM*TYPE_WIDTH  same packing as typeData
o_typeRule_keyOffset  out  KEY_FILED_NUM*KEY_OFFSET_WIDTH  offset[j] at bits [j*KEY_OFFSET_WIDTH+:KEY_OFFSET_WIDTH]
o_resp_valid  out  1  status response valid
o_resp_data  out  32  status response word
i_resp_ready  in  1  response accepted

Behaviour:
- Handshake: a word transfers when i_cfg_valid & o_cfg_ready. A response transfers when o_resp_valid & i_resp_ready.
- o_resp_valid and o_resp_data hold stable until the response is accepted.
- Header word: [31:28] opcode, [27:16] ignored, [15:0] rule index.
- Opcodes: 1 = WRITE; 2 = INVALIDATE rule; 3 = INVALIDATE_ALL (index ignored). Any other opcode is an error.
- WRITE payload: DATA_BEATS typeData words, then DATA_BEATS typeMask words, then OFF_BEATS keyOffset words.
- Payload packing: LSB-first, word k fills bits [32k+:32]. Bits beyond the field width are discarded.
- States: IDLE, DATA, MASK, OFFS, DRAIN, COMMIT, RESP.
- o_cfg_ready is 1 in IDLE, DATA, MASK, OFFS and DRAIN. It is 0 in COMMIT and RESP.
- IDLE, header accepted:
  - WRITE with index < RULE_NUM -> DATA.
  - WRITE with index >= RULE_NUM -> DRAIN. DRAIN consumes 2*DATA_BEATS+OFF_BEATS words with no write, then goes to RESP with status 2.
  - INVALIDATE or INVALIDATE_ALL -> COMMIT with valid=0. For INVALIDATE, index >= RULE_NUM goes directly to RESP with status 2.
  - Bad opcode -> RESP with status 1; no payload is consumed.
- DATA -> MASK -> OFFS: each state advances after its last beat is accepted. A beat counter resets on every state entry.
- COMMIT lasts exactly one cycle:
  - o_rule_wren is one-hot at the index for WRITE/INVALIDATE, or all ones for INVALIDATE_ALL.
  - o_typeRule_valid is 1 for WRITE, 0 otherwise.
  - Data, mask and offset outputs hold the assembled record.
  - COMMIT then goes to RESP with status 0.
- Latency: o_rule_wren asserts the cycle after the last payload beat (or the header) is accepted. o_resp_valid asserts the following cycle.
- RESP: o_resp_valid=1. o_resp_data = {opcode[3:0], 10'b0, status[1:0], index[15:0]}. On acceptance the block returns to IDLE.
- Outputs: o_typeRule_* are registered and change only in COMMIT. o_rule_wren is 0 in every state except COMMIT.
- Idle cycles between payload beats are allowed; a partially assembled record is held indefinitely.
- Reset, including mid-command: state returns to IDLE and all outputs go to 0, except o_cfg_ready=1 after reset. Any partial record is discarded with no write and no response.

Optional Feature:
TYPE_RULE_CFG_CHECK_EN:
- Defined: during OFFS, any typeData bit set where typeMask is 0 marks the WRITE inconsistent, because such a rule can never hit. An inconsistent WRITE skips COMMIT and returns status 3 with no strobe. All payload beats are still consumed.
- Undefined: no check is made; the write commits as given with status 0.

Test Plan:
- Beats 0x10000003, 0x08000006, 0xFFFFFFFF, 0x04030201, 0x08070605 -> one cycle with o_rule_wren=0x0008, valid=1, typeData=0x08000006, typeMask=0xFFFFFFFF, keyOffset=0x0807060504030201. The next cycle o_resp_data=0x10000003.
- Header 0x20000005 -> o_rule_wren=0x0020 for one cycle with valid=0; response 0x20000005. Header 0x30000000 -> o_rule_wren=0xFFFF with valid=0; response 0x30000000.
- Header 0x10000020 followed by 4 payload words -> all 4 words accepted, no wren; response 0x10020020. Header 0x7000000A -> no payload consumed; response 0x7001000A.
- i_resp_ready held 0 for 10 cycles after a write -> o_cfg_ready=0 and the response is held stable. After i_resp_ready rises, the next header is accepted.
- i_rst_n asserted after 2 of 4 payload beats -> no wren and no response. A fresh complete write afterwards succeeds with status 0.
- With TYPE_RULE_CFG_CHECK_EN defined: data 0x00000001 and mask 0xFFFF0000 -> no wren; response status 3, e.g. 0x10030003 for index 3.
